// File: rtl/shake_squeeze_unpacker.sv
// Serialises SHAKE squeeze blocks into 16-bit little-endian samples,
// pulling exactly as many blocks as the requested word count needs.
//   state | meaning
//   IDLE  | waiting for start_i
//   LOAD  | accepting the next squeeze block from upstream
//   DRAIN | presenting words of the captured block
//   DONE  | one-cycle completion pulse
module shake_squeeze_unpacker #(
  parameter int DW = 1344,
  parameter int OW = 16,
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          sel_shake128_i,
  input  logic [CW-1:0] count_i,
  input  logic [DW-1:0] shake_dout_i,
  input  logic          shake_dout_valid_i,
  output logic          shake_dout_ready_o,
  output logic [OW-1:0] word_o,
  output logic          word_valid_o,
  input  logic          word_ready_i,
  output logic          busy_o,
  output logic          done_o
);

  localparam int W128 = (168 * 8) / OW;
  localparam int W256 = (136 * 8) / OW;
  localparam logic [6:0] LAST128 = 7'(W128 - 1);
  localparam logic [6:0] LAST256 = 7'(W256 - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t        state;
  logic [DW-1:0] blk_q;
  logic [CW-1:0] rem;
  logic [6:0]    idx;
  logic          sel;
  logic [6:0]    last_idx;

  assign last_idx = sel ? LAST128 : LAST256;

  // Bytes sit MSB-first in the block; the first two form one little-endian word.
  assign word_o = {blk_q[DW-9:DW-16], blk_q[DW-1:DW-8]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state              <= IDLE;
      blk_q              <= '0;
      rem                <= '0;
      idx                <= '0;
      sel                <= 1'b0;
      shake_dout_ready_o <= 1'b0;
      word_valid_o       <= 1'b0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            sel    <= sel_shake128_i;
            busy_o <= 1'b1;
            if (count_i == '0) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              rem                <= count_i;
              shake_dout_ready_o <= 1'b1;
              state              <= LOAD;
            end
          end
        end
        LOAD: begin
          if (shake_dout_valid_i && shake_dout_ready_o) begin
            blk_q              <= shake_dout_i;
            idx                <= '0;
            shake_dout_ready_o <= 1'b0;
            word_valid_o       <= 1'b1;
            state              <= DRAIN;
          end
        end
        DRAIN: begin
          if (word_valid_o && word_ready_i) begin
            blk_q <= {blk_q[DW-OW-1:0], {OW{1'b0}}};
            idx   <= idx + 7'd1;
            rem   <= rem - CW'(1);
            // Running out of words wins over a block boundary: no extra pop.
            if (rem == CW'(1)) begin
              word_valid_o <= 1'b0;
              done_o       <= 1'b1;
              state        <= DONE;
            end else if (idx == last_idx) begin
              word_valid_o       <= 1'b0;
              shake_dout_ready_o <= 1'b1;
              state              <= LOAD;
            end
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shake_squeeze_unpacker.sv
// Scoreboard bench for shake_squeeze_unpacker: expected words come from a
// byte-indexed model of the squeeze blocks; a monitor pops and compares.
module tb_shake_squeeze_unpacker;
  localparam int DW = 1344;
  localparam int OW = 16;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          sel_shake128_i = 1'b0;
  logic [CW-1:0] count_i = '0;
  logic [DW-1:0] shake_dout_i = '0;
  logic          shake_dout_valid_i = 1'b0;
  logic          shake_dout_ready_o;
  logic [OW-1:0] word_o;
  logic          word_valid_o;
  logic          word_ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;

  shake_squeeze_unpacker #(.DW(DW), .OW(OW), .CW(CW)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .start_i            (start_i),
    .sel_shake128_i     (sel_shake128_i),
    .count_i            (count_i),
    .shake_dout_i       (shake_dout_i),
    .shake_dout_valid_i (shake_dout_valid_i),
    .shake_dout_ready_o (shake_dout_ready_o),
    .word_o             (word_o),
    .word_valid_o       (word_valid_o),
    .word_ready_i       (word_ready_i),
    .busy_o             (busy_o),
    .done_o             (done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] up_q[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];
  int hs_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int acc_cyc = -10;
  bit stall = 1'b0;
  bit req_nonzero = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [DW-1:0] b, input int j);
    return b[DW-1-8*j -: 8];
  endfunction

  function automatic logic [DW-1:0] rand_block();
    logic [DW-1:0] b;
    for (int i = 0; i < DW/32; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Upstream squeeze source: presents queued blocks after a random delay.
  initial begin
    bit hs;
    forever begin
      @(negedge clk_i);
      hs = rst_ni && shake_dout_valid_i && shake_dout_ready_o;
      @(posedge clk_i);
      #1;
      if (!rst_ni) begin
        up_q.delete();
        shake_dout_valid_i = 1'b0;
      end else begin
        if (hs) begin
          void'(up_q.pop_front());
          hs_cnt++;
          shake_dout_valid_i = 1'b0;
        end
        if (!shake_dout_valid_i && up_q.size() > 0 && $urandom_range(0, 3) == 0) begin
          shake_dout_valid_i = 1'b1;
          shake_dout_i       = up_q[0];
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      word_ready_i = !stall && ($urandom_range(0, 4) != 0);
    end
  end

  // Monitor: protocol checks plus scoreboard pop on every accepted word.
  initial begin
    bit prev_stall = 1'b0;
    bit prev_done = 1'b0;
    logic [OW-1:0] prev_word = '0;
    logic [OW-1:0] e;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        chk("ready_with_valid", 32'(shake_dout_ready_o & word_valid_o), 32'd0);
        chk("busy", 32'(busy_o), 32'(shake_dout_ready_o | word_valid_o | done_o));
        if (prev_stall) begin
          chk("hold_valid", 32'(word_valid_o), 32'd1);
          chk("hold_word", 32'(word_o), 32'(prev_word));
        end
        if (word_valid_o && word_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(word_o), 32'hffffffff);
          end else begin
            e = exp_q.pop_front();
            chk("word", 32'(word_o), 32'(e));
          end
          got_q.push_back(word_o);
          acc_cyc = cyc;
        end
        if (done_o) begin
          done_cnt++;
          chk("done_single", 32'(prev_done), 32'd0);
          chk("done_words_left", 32'(exp_q.size()), 32'd0);
          if (req_nonzero) chk("done_latency", 32'(cyc - acc_cyc), 32'd1);
        end
        prev_done  = done_o;
        prev_stall = word_valid_o && !word_ready_i;
        prev_word  = word_o;
      end
    end
  end

  task automatic pulse_start(input bit sel, input int cnt);
    @(posedge clk_i);
    #1;
    start_i        = 1'b1;
    sel_shake128_i = sel;
    count_i        = CW'(cnt);
    @(posedge clk_i);
    #1;
    start_i        = 1'b0;
    sel_shake128_i = 1'($urandom);
    count_i        = CW'($urandom);
  endtask

  task automatic prep_req(input bit sel, input int cnt, input logic [63:0] p0, input int n0,
                          input logic [63:0] p1, input int n1, output int nb);
    int wpb;
    logic [DW-1:0] blks[$];
    logic [DW-1:0] b;
    wpb = sel ? 84 : 68;
    nb  = (cnt + wpb - 1) / wpb;
    for (int i = 0; i < nb; i++) begin
      b = rand_block();
      if (i == 0) for (int j = 0; j < n0; j++) b[DW-1-8*j -: 8] = p0[8*(n0-1-j) +: 8];
      if (i == 1) for (int j = 0; j < n1; j++) b[DW-1-8*j -: 8] = p1[8*(n1-1-j) +: 8];
      blks.push_back(b);
      up_q.push_back(b);
    end
    for (int k = 0; k < cnt; k++)
      exp_q.push_back({byte_of(blks[k/wpb], 2*(k%wpb)+1), byte_of(blks[k/wpb], 2*(k%wpb))});
    got_q.delete();
    req_nonzero = (cnt != 0);
  endtask

  task automatic run_req(input string name, input bit sel, input int cnt,
                         input logic [63:0] p0, input int n0, input logic [63:0] p1, input int n1,
                         input bit stall_mid, input bit busy_poke);
    int nb, hs0, done0, budget, t;
    prep_req(sel, cnt, p0, n0, p1, n1, nb);
    hs0    = hs_cnt;
    done0  = done_cnt;
    budget = (cnt == 0) ? 3 : cnt*8 + nb*40 + 50;
    pulse_start(sel, cnt);
    if (busy_poke) begin
      repeat (4) @(posedge clk_i);
      pulse_start(!sel, 7);
    end
    if (stall_mid) begin
      for (t = 0; t < 2000 && got_q.size() < 10; t++) @(posedge clk_i);
      @(posedge clk_i);
      #1;
      stall = 1'b1;
      repeat (5) @(posedge clk_i);
      #1;
      stall = 1'b0;
    end
    for (t = 0; t < budget && done_cnt == done0; t++) @(posedge clk_i);
    if (done_cnt == done0) $display("FAIL %s_timeout got=no_done exp=done", name);
    chk({name, "_done"}, 32'(done_cnt - done0), 32'd1);
    @(negedge clk_i);
    chk({name, "_handshakes"}, 32'(hs_cnt - hs0), 32'(nb));
    chk({name, "_words"}, 32'(got_q.size()), 32'(cnt));
    repeat (2) @(posedge clk_i);
  endtask

  initial begin
    int nb, t, done0;
    #1;
    chk("rst_word_valid", 32'(word_valid_o), 32'd0);
    chk("rst_ready", 32'(shake_dout_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_word", 32'(word_o), 32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_req("s128_c3", 1'b1, 3, 64'h0c30ef281d3d, 6, 64'h0, 0, 1'b0, 1'b0);
    if (got_q.size() == 3) begin
      chk("s128_w0", 32'(got_q[0]), 32'h300c);
      chk("s128_w1", 32'(got_q[1]), 32'h28ef);
      chk("s128_w2", 32'(got_q[2]), 32'h3d1d);
    end

    run_req("s128_c85", 1'b1, 85, 64'h0c30ef281d3d, 6, 64'hb8f860da, 4, 1'b0, 1'b0);
    if (got_q.size() == 85) begin
      chk("s128_w0b", 32'(got_q[0]), 32'h300c);
      chk("s128_w84", 32'(got_q[84]), 32'hf8b8);
    end

    run_req("s256_c68", 1'b0, 68, 64'h1138fe10, 4, 64'h0, 0, 1'b0, 1'b0);
    if (got_q.size() == 68) begin
      chk("s256_w0", 32'(got_q[0]), 32'h3811);
      chk("s256_w1", 32'(got_q[1]), 32'h10fe);
    end

    run_req("s256_c69", 1'b0, 69, 64'h1138fe10, 4, 64'h03962bd0, 4, 1'b0, 1'b0);
    if (got_q.size() == 69) chk("s256_w68", 32'(got_q[68]), 32'h9603);

    run_req("count0", 1'b1, 0, 64'h0, 0, 64'h0, 0, 1'b0, 1'b0);
    run_req("stall", 1'b1, 150, 64'h0, 0, 64'h0, 0, 1'b1, 1'b0);
    run_req("busy_start", 1'b0, 100, 64'h0, 0, 64'h0, 0, 1'b0, 1'b1);

    prep_req(1'b1, 200, 64'h0, 0, 64'h0, 0, nb);
    pulse_start(1'b1, 200);
    for (t = 0; t < 2000 && got_q.size() < 5; t++) @(posedge clk_i);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("arst_word_valid", 32'(word_valid_o), 32'd0);
    chk("arst_ready", 32'(shake_dout_ready_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    done0 = done_cnt;
    exp_q.delete();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    chk("arst_no_done", 32'(done_cnt), 32'(done0));
    run_req("after_rst", 1'b1, 5, 64'h0, 0, 64'h0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_req("rand", 1'($urandom), int'($urandom_range(0, 260)), 64'h0, 0, 64'h0, 0,
              1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
